web_pwr_seq: RTL and testbench

- Power-state sequencer for a wake-event block (web instance).
- Consumes that block's `wake`, `activate_low_pwr` and `epu_enable` event outputs.
- Runs the req/ack handshake with the power-management unit (PMU).
- Drives the web's `clear_function` input to retire the serviced `activate_low_pwr` event, so software sees one complete low-power round trip.
- Sits beside each web instance in the tile, same clock domain.

---
 rtl/web_pwr_seq.sv | 220 ++++++++++++++++++++++
 tb/tb_web_pwr_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/web_pwr_seq.sv
// web_pwr_seq
//   Power-state sequencer sitting beside a wake-event block (web). It turns the
//   web's activate_low_pwr event into a PMU req/ack round trip, returns on wake
//   or on a PMU-initiated exit, then pulses clear_function so the web retires
//   the serviced event.
//
//   Optional build macro: WEB_PWR_SEQ_WAKE_CNT_EN
//     When defined, adds a 16-bit saturating wake_count output that counts
//     SLEEP->EXIT transitions caused by wake. When undefined, the port and its
//     counter do not exist.
module web_pwr_seq #(
    parameter int CNT_W       = 8,
    parameter int CLR_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic             clkclk,
    input  logic             sysreset_n,
    input  logic             wake,
    input  logic             activate_low_pwr,
    input  logic             epu_enable,
    input  logic [CNT_W-1:0] cfg_entry_dly,
    input  logic [CNT_W-1:0] cfg_settle_dly,
    input  logic             pmu_ack,
    output logic             pmu_req,
    output logic             clear_function,
    output logic [2:0]       seq_state,
`ifdef WEB_PWR_SEQ_WAKE_CNT_EN
    output logic [15:0]      wake_count,
`endif
    output logic             err_timeout
);

    // The ack-wait counter only ever needs to reach ACK_TIMEOUT-1, and the
    // clear counter CLR_CYCLES-1, so size them to those maxima.
    localparam int TO_W         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int CLR_W        = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int GUARD_CYCLES = 4;

    localparam bit               TO_EN      = (ACK_TIMEOUT > 0);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
    localparam logic [CLR_W-1:0] CLR_LAST   = CLR_W'(CLR_CYCLES - 1);
    localparam logic [2:0]       GUARD_LOAD = 3'(GUARD_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_REQ    = 3'd2,
        ST_SLEEP  = 3'd3,
        ST_EXIT   = 3'd4,
        ST_SETTLE = 3'd5,
        ST_CLEAR  = 3'd6
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] dly_cnt;
    logic [CNT_W-1:0] dly_cnt_nx;
    logic [TO_W-1:0]  ack_cnt;
    logic [TO_W-1:0]  ack_cnt_nx;
    logic [CLR_W-1:0] clr_cnt;
    logic [CLR_W-1:0] clr_cnt_nx;
    logic [2:0]       guard_cnt;
    logic [2:0]       guard_cnt_nx;
    logic             ack_expired;
    logic             timeout_hit;

    // A zero ACK_TIMEOUT keeps ack_expired low forever, disabling the abort.
    assign ack_expired = TO_EN && (ack_cnt == TO_LAST);

    // Debug view of the sequencer is simply the state register.
    assign seq_state = state;

    // Next-state and next-counter logic; every counter holds unless a branch
    // below loads or decrements it, and a counter at zero transitions rather
    // than wrapping.
    always_comb begin
        state_nx     = state;
        dly_cnt_nx   = dly_cnt;
        ack_cnt_nx   = ack_cnt;
        clr_cnt_nx   = clr_cnt;
        guard_cnt_nx = guard_cnt;
        timeout_hit  = 1'b0;

        case (state)
            ST_IDLE: begin
                // Right after CLEAR the web's event is still visible through
                // its synchronizer, so hold off before honouring it again.
                if (guard_cnt != 3'd0) begin
                    guard_cnt_nx = guard_cnt - 3'd1;
                end else if (activate_low_pwr) begin
                    if (wake) begin
                        state_nx   = ST_CLEAR;
                        clr_cnt_nx = CLR_LAST;
                    end else begin
                        state_nx   = ST_ENTRY;
                        dly_cnt_nx = cfg_entry_dly;
                    end
                end
            end

            ST_ENTRY: begin
                if (wake) begin
                    state_nx   = ST_CLEAR;
                    clr_cnt_nx = CLR_LAST;
                end else if (dly_cnt == '0) begin
                    state_nx   = ST_REQ;
                    ack_cnt_nx = '0;
                end else begin
                    dly_cnt_nx = dly_cnt - CNT_W'(1);
                end
            end

            ST_REQ: begin
                // Wake is deliberately not looked at: once the request is
                // raised the handshake is always completed.
                if (pmu_ack) begin
                    state_nx = ST_SLEEP;
                end else if (ack_expired) begin
                    state_nx    = ST_CLEAR;
                    clr_cnt_nx  = CLR_LAST;
                    timeout_hit = 1'b1;
                end else begin
                    ack_cnt_nx = ack_cnt + TO_W'(1);
                end
            end

            ST_SLEEP: begin
                // SLEEP is only entered with ack high, so ack low here means
                // the PMU dropped it and is driving the exit itself.
                if ((wake && !epu_enable) || !pmu_ack) begin
                    state_nx   = ST_EXIT;
                    ack_cnt_nx = '0;
                end
            end

            ST_EXIT: begin
                if (!pmu_ack) begin
                    state_nx   = ST_SETTLE;
                    dly_cnt_nx = cfg_settle_dly;
                end else if (ack_expired) begin
                    state_nx    = ST_CLEAR;
                    clr_cnt_nx  = CLR_LAST;
                    timeout_hit = 1'b1;
                end else begin
                    ack_cnt_nx = ack_cnt + TO_W'(1);
                end
            end

            ST_SETTLE: begin
                if (dly_cnt == '0) begin
                    state_nx   = ST_CLEAR;
                    clr_cnt_nx = CLR_LAST;
                end else begin
                    dly_cnt_nx = dly_cnt - CNT_W'(1);
                end
            end

            ST_CLEAR: begin
                if (clr_cnt == '0) begin
                    state_nx     = ST_IDLE;
                    guard_cnt_nx = GUARD_LOAD;
                end else begin
                    clr_cnt_nx = clr_cnt - CLR_W'(1);
                end
            end

            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; outputs are decoded from the
    // next state so they line up with the state register.
    always_ff @(posedge clkclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            state          <= ST_IDLE;
            dly_cnt        <= '0;
            ack_cnt        <= '0;
            clr_cnt        <= '0;
            guard_cnt      <= '0;
            pmu_req        <= 1'b0;
            clear_function <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            state          <= state_nx;
            dly_cnt        <= dly_cnt_nx;
            ack_cnt        <= ack_cnt_nx;
            clr_cnt        <= clr_cnt_nx;
            guard_cnt      <= guard_cnt_nx;
            pmu_req        <= (state_nx == ST_REQ) || (state_nx == ST_SLEEP);
            clear_function <= (state_nx == ST_CLEAR);
            if (timeout_hit) begin
                err_timeout <= 1'b1;
            end
        end
    end

`ifdef WEB_PWR_SEQ_WAKE_CNT_EN
    logic wake_exit;

    // Saturating increment for the wake statistics counter.
    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Only a wake-driven exit counts; a PMU-initiated exit does not.
    assign wake_exit = (state == ST_SLEEP) && wake && !epu_enable;

    // Count wake-driven SLEEP->EXIT transitions, sticking at all-ones.
    always_ff @(posedge clkclk or negedge sysreset_n) begin
        if (!sysreset_n) begin
            wake_count <= 16'd0;
        end else if (wake_exit) begin
            wake_count <= sat_inc16(wake_count);
        end
    end
`endif

endmodule

// File: tb/tb_web_pwr_seq.sv
// tb_web_pwr_seq
//   Randomized transactions for web_pwr_seq. Each transaction is described by
//   a handful of segment lengths (entry delay, ack latency, sleep time, exit
//   ack hold, settle delay); the expected per-cycle state is laid out from
//   those lengths, with don't-care inputs randomized along the way.
module tb_web_pwr_seq;

    localparam int CNT_W       = 8;
    localparam int CLR_CYCLES  = 4;
    localparam int ACK_TIMEOUT = 16;

    localparam int S_IDLE   = 0;
    localparam int S_ENTRY  = 1;
    localparam int S_REQ    = 2;
    localparam int S_SLEEP  = 3;
    localparam int S_EXIT   = 4;
    localparam int S_SETTLE = 5;
    localparam int S_CLEAR  = 6;

    localparam int K_WAKE     = 0;
    localparam int K_PMU_EXIT = 1;
    localparam int K_ENT_ABRT = 2;
    localparam int K_IDL_ABRT = 3;
    localparam int K_REQ_TO   = 4;
    localparam int K_EXIT_TO  = 5;
    localparam int K_RESET    = 6;

    logic             clkclk = 1'b0;
    logic             sysreset_n;
    logic             wake;
    logic             activate_low_pwr;
    logic             epu_enable;
    logic [CNT_W-1:0] cfg_entry_dly;
    logic [CNT_W-1:0] cfg_settle_dly;
    logic             pmu_ack;
    logic             pmu_req;
    logic             clear_function;
    logic [2:0]       seq_state;
    logic             err_timeout;
`ifdef WEB_PWR_SEQ_WAKE_CNT_EN
    logic [15:0]      wake_count;
`endif

    web_pwr_seq #(
        .CNT_W       (CNT_W),
        .CLR_CYCLES  (CLR_CYCLES),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clkclk           (clkclk),
        .sysreset_n       (sysreset_n),
        .wake             (wake),
        .activate_low_pwr (activate_low_pwr),
        .epu_enable       (epu_enable),
        .cfg_entry_dly    (cfg_entry_dly),
        .cfg_settle_dly   (cfg_settle_dly),
        .pmu_ack          (pmu_ack),
        .pmu_req          (pmu_req),
        .clear_function   (clear_function),
        .seq_state        (seq_state),
`ifdef WEB_PWR_SEQ_WAKE_CNT_EN
        .wake_count       (wake_count),
`endif
        .err_timeout      (err_timeout)
    );

    always #5 clkclk = ~clkclk;

    typedef struct {
        bit               act;
        bit               wk;
        bit               epu;
        bit               ack;
        logic [CNT_W-1:0] edly;
        logic [CNT_W-1:0] sdly;
        int               st;
        bit               err;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_err  = 1'b0;
    int   m_wcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Queue one clock: inputs sampled on that edge and the state expected after
    // it. A negative delay value means the config input is a don't-care.
    task automatic push(input bit a, input bit w, input bit e, input bit k,
                        input int st, input int ed, input int sd);
        vec_t v;
        v.act  = a;
        v.wk   = w;
        v.epu  = e;
        v.ack  = k;
        v.st   = st;
        v.err  = m_err;
        v.edly = (ed < 0) ? CNT_W'($urandom_range(0, 255)) : CNT_W'(ed);
        v.sdly = (sd < 0) ? CNT_W'($urandom_range(0, 255)) : CNT_W'(sd);
        vq.push_back(v);
    endtask

    task automatic p(input bit a, input bit w, input bit e, input bit k, input int st);
        push(a, w, e, k, st, -1, -1);
    endtask

    // Remaining CLEAR cycles, then the guarded IDLE window with the event still
    // set (and wake toggling), then the event finally drops.
    task automatic clear_tail();
        for (int i = 1; i < CLR_CYCLES; i++) p(1'b1, rb(), rb(), 1'b0, S_CLEAR);
        p(1'b1, rb(), rb(), 1'b0, S_IDLE);
        for (int i = 0; i < 4; i++) p(1'b1, rb(), rb(), 1'b0, S_IDLE);
        for (int i = 0; i <= int'($urandom_range(0, 2)); i++) p(1'b0, rb(), rb(), 1'b0, S_IDLE);
    endtask

    task automatic bump_wcnt();
        if (m_wcnt < 16'hFFFF) m_wcnt++;
    endtask

    // e: entry delay, a: REQ cycles before ack, w: free SLEEP cycles,
    // m: SLEEP cycles with wake masked by EPU, x: EXIT cycles with ack held,
    // s: settle delay.
    task automatic build(input int kind, input int e, input int a, input int w,
                         input int m, input int x, input int s);
        int  j;
        bit  wk;
        if (kind == K_IDL_ABRT) begin
            p(1'b1, 1'b1, rb(), 1'b0, S_CLEAR);
            clear_tail();
            return;
        end
        j = (kind == K_ENT_ABRT) ? int'($urandom_range(1, e + 1)) : e + 1;
        push(1'b1, 1'b0, rb(), 1'b0, S_ENTRY, e, -1);
        for (int i = 1; i < j; i++) p(1'b1, 1'b0, rb(), 1'b0, S_ENTRY);
        if (kind == K_ENT_ABRT) begin
            p(1'b1, 1'b1, rb(), 1'b0, S_CLEAR);
            clear_tail();
            return;
        end
        p(1'b1, 1'b0, rb(), 1'b0, S_REQ);
        if (kind == K_REQ_TO) begin
            for (int i = 1; i < ACK_TIMEOUT; i++) p(1'b1, rb(), rb(), 1'b0, S_REQ);
            m_err = 1'b1;
            p(1'b1, rb(), rb(), 1'b0, S_CLEAR);
            clear_tail();
            return;
        end
        for (int i = 0; i < a; i++) p(1'b1, rb(), rb(), 1'b0, S_REQ);
        p(1'b1, rb(), rb(), 1'b1, S_SLEEP);
        for (int i = 0; i < w; i++) begin
            wk = rb();
            p(1'b1, wk, wk ? 1'b1 : rb(), 1'b1, S_SLEEP);
        end
        for (int i = 0; i < m; i++) p(1'b1, 1'b1, 1'b1, 1'b1, S_SLEEP);
        if (kind == K_RESET) return;
        if (kind == K_PMU_EXIT) begin
            wk = rb();
            p(1'b1, wk, wk ? 1'b1 : rb(), 1'b0, S_EXIT);
        end else begin
            p(1'b1, 1'b1, 1'b0, 1'b1, S_EXIT);
            bump_wcnt();
            if (kind == K_EXIT_TO) begin
                for (int i = 1; i < ACK_TIMEOUT; i++) p(1'b1, rb(), rb(), 1'b1, S_EXIT);
                m_err = 1'b1;
                p(1'b1, rb(), rb(), 1'b1, S_CLEAR);
                clear_tail();
                return;
            end
            for (int i = 0; i < x; i++) p(1'b1, rb(), rb(), 1'b1, S_EXIT);
        end
        push(1'b1, rb(), rb(), 1'b0, S_SETTLE, -1, s);
        for (int i = 0; i < s; i++) p(1'b1, rb(), rb(), 1'b0, S_SETTLE);
        p(1'b1, rb(), rb(), 1'b0, S_CLEAR);
        clear_tail();
    endtask

    // Drive each queued vector at the falling edge and check after the next
    // rising edge, again at a falling edge.
    task automatic run_q();
        vec_t v;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            activate_low_pwr = v.act;
            wake             = v.wk;
            epu_enable       = v.epu;
            pmu_ack          = v.ack;
            cfg_entry_dly    = v.edly;
            cfg_settle_dly   = v.sdly;
            @(posedge clkclk);
            @(negedge clkclk);
            chk("seq_state", 32'(seq_state), 32'(v.st));
            chk("pmu_req", 32'(pmu_req), 32'(v.st == S_REQ || v.st == S_SLEEP));
            chk("clear_function", 32'(clear_function), 32'(v.st == S_CLEAR));
            chk("err_timeout", 32'(err_timeout), 32'(v.err));
        end
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must fall before
    // any clock edge arrives.
    task automatic mid_reset();
        #2;
        sysreset_n = 1'b0;
        #1;
        chk("rst_pmu_req", 32'(pmu_req), 32'd0);
        chk("rst_clear_function", 32'(clear_function), 32'd0);
        chk("rst_seq_state", 32'(seq_state), 32'd0);
        chk("rst_err_timeout", 32'(err_timeout), 32'd0);
        activate_low_pwr = 1'b0;
        wake             = 1'b0;
        pmu_ack          = 1'b0;
        epu_enable       = 1'b0;
        @(negedge clkclk);
        sysreset_n = 1'b1;
        m_err  = 1'b0;
        m_wcnt = 0;
        @(posedge clkclk);
        @(negedge clkclk);
        chk("post_rst_seq_state", 32'(seq_state), 32'(S_IDLE));
        chk("post_rst_pmu_req", 32'(pmu_req), 32'd0);
    endtask

    task automatic txn(input int kind, input int e, input int a, input int w,
                       input int m, input int x, input int s);
        build(kind, e, a, w, m, x, s);
        run_q();
        if (kind == K_RESET) mid_reset();
    endtask

    initial begin
        sysreset_n       = 1'b0;
        wake             = 1'b0;
        activate_low_pwr = 1'b0;
        epu_enable       = 1'b0;
        pmu_ack          = 1'b0;
        cfg_entry_dly    = '0;
        cfg_settle_dly   = '0;
        repeat (3) @(negedge clkclk);
        chk("reset_seq_state", 32'(seq_state), 32'd0);
        chk("reset_pmu_req", 32'(pmu_req), 32'd0);
        chk("reset_clear_function", 32'(clear_function), 32'd0);
        chk("reset_err_timeout", 32'(err_timeout), 32'd0);
`ifdef WEB_PWR_SEQ_WAKE_CNT_EN
        chk("reset_wake_count", 32'(wake_count), 32'd0);
`endif
        sysreset_n = 1'b1;
        @(negedge clkclk);

        // Directed walk-throughs first, then a randomized mix.
        txn(K_WAKE, 3, 1, 2, 0, 2, 2);
        txn(K_ENT_ABRT, 3, 0, 0, 0, 0, 0);
        txn(K_WAKE, 2, 3, 1, 50, 1, 1);
        txn(K_WAKE, 0, 0, 0, 0, 0, 0);
        txn(K_PMU_EXIT, 1, 2, 3, 2, 0, 3);
        txn(K_IDL_ABRT, 0, 0, 0, 0, 0, 0);
        txn(K_REQ_TO, 2, 0, 0, 0, 0, 0);
        txn(K_WAKE, 1, 1, 1, 0, 1, 1);
        txn(K_RESET, 1, 1, 2, 3, 0, 0);
        txn(K_EXIT_TO, 1, 0, 1, 0, 0, 0);
        txn(K_RESET, 0, 0, 0, 0, 0, 0);

        for (int t = 0; t < 60; t++) begin
            txn(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 12)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 10)),
                int'($urandom_range(0, 5)));
        end
        txn(K_WAKE, 1, 0, 0, 0, 0, 1);

`ifdef WEB_PWR_SEQ_WAKE_CNT_EN
        chk("wake_count", 32'(wake_count), 32'(m_wcnt));
        force dut.wake_count = 16'hFFFE;
        @(negedge clkclk);
        release dut.wake_count;
        m_wcnt = 16'hFFFE;
        txn(K_WAKE, 0, 0, 0, 0, 0, 0);
        chk("wake_count_top", 32'(wake_count), 32'hFFFF);
        txn(K_WAKE, 1, 1, 0, 0, 1, 0);
        chk("wake_count_sat", 32'(wake_count), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
